// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle for bin_to_bcd_seq.
// The requester (master) drives start/bin_in; the converter (slave) drives busy/done/bcd_out/ovf.
interface bin_to_bcd_seq_if #(
  parameter int IN_W = 14
);
  logic            start;
  logic [IN_W-1:0] bin_in;
  logic            busy;
  logic            done;
  logic [15:0]     bcd_out;
  logic            ovf;

  modport master (
    output start, bin_in,
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
    output busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter using shift-and-add-3 (double dabble).
// One input bit is consumed per SHIFT cycle. Start-to-done latency is IN_W+1
// cycles, and the shortest back-to-back period is IN_W+2 cycles.
// A 5-digit accumulator is kept so that values above 9999 raise ovf.
// Optional macro BIN_TO_BCD_SAT_EN: when defined, an overflowing result is
// displayed as 16'h9999. Otherwise bcd_out shows the lower four digits.
module bin_to_bcd_seq #(
  parameter int IN_W = 14
) (
  input  logic            clk,
  input  logic            reset_p,
  bin_to_bcd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [19:0]     acc_q, acc_d;
  logic [IN_W-1:0] shreg_q, shreg_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     bcd_q, bcd_d;
  logic            ovf_q, ovf_d;

  // Add 3 to each digit that is 5 or more. The following left shift then
  // carries that digit correctly into the next decimal place.
  logic [19:0] acc_adj;
  for (genvar gi = 0; gi < 5; gi++) begin : g_adj
    assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ?
                                (acc_q[gi*4 +: 4] + 4'd3) : acc_q[gi*4 +: 4];
  end

  // Next-state and datapath logic. Everything holds unless its state updates it.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shreg_d = bus.bin_in;
          acc_d   = '0;
          cnt_d   = 4'(IN_W);
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, shreg_d} = {acc_adj[18:0], shreg_q, 1'b0};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ovf_d = (acc_q[19:16] != 4'd0);
`ifdef BIN_TO_BCD_SAT_EN
        bcd_d = (acc_q[19:16] != 4'd0) ? 16'h9999 : acc_q[15:0];
`else
        bcd_d = acc_q[15:0];
`endif
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register. Reset is asynchronous so that a conversion can be aborted at any time.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      shreg_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq (IN_W = 14).
// Expected values are worked out by hand. They follow BIN_TO_BCD_SAT_EN when it is defined.
module tb_bin_to_bcd_seq;

  localparam int IN_W = 14;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  int   n_asserts = 0;
  int   n_fail = 0;
  int   lat;
  int   busy_cnt;
  int   extra_done;

  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.IN_W(IN_W)) bus ();

  bin_to_bcd_seq #(.IN_W(IN_W)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  // Advance one cycle and sample 1 ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Accept one conversion at the next edge, then wait (bounded) for done.
  // With noise=1, start is pulsed with bin_in=7777 while the converter is busy.
  task automatic conv(input string tag, input logic [13:0] v, input logic [15:0] exp_bcd,
                      input logic exp_ovf, input bit noise);
    int n;
    int bc;
    bus.start  = 1'b1;
    bus.bin_in = v;
    cyc();                               // E0
    bus.start = 1'b0;
    chk({tag, "_busy_after_accept"}, 32'(bus.busy), 32'd1);
    chk({tag, "_done_low_after_accept"}, 32'(bus.done), 32'd0);
    n  = 0;
    bc = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy) bc++;
      if (noise && n >= 3 && n <= 6) begin
        bus.start  = 1'b1;
        bus.bin_in = 14'd7777;
      end else begin
        bus.start = 1'b0;
      end
      cyc();
      n++;
    end
    bus.start = 1'b0;
    lat      = n;
    busy_cnt = bc;
    chk({tag, "_latency"}, 32'(n), 32'd15);
    chk({tag, "_busy_cycles"}, 32'(bc), 32'd15);
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp_bcd));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
  endtask

  initial begin
    logic [15:0] exp_big;
    logic [15:0] exp_max;
`ifdef BIN_TO_BCD_SAT_EN
    exp_big = 16'h9999;
    exp_max = 16'h9999;
`else
    exp_big = 16'h2345;
    exp_max = 16'h6383;
`endif
    bus.start  = 1'b0;
    bus.bin_in = '0;

    // Hold reset for a few cycles, then release it just after an edge.
    repeat (3) cyc();
    chk("reset_outputs", {13'd0, bus.busy, bus.done, bus.ovf, bus.bcd_out}, 32'd0);
    reset_p = 1'b0;

    // With no start, the outputs must stay at their reset values.
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("idle_outputs", {13'd0, bus.busy, bus.done, bus.ovf, bus.bcd_out}, 32'd0);
    end

    // Basic conversion. done must last exactly one cycle.
    conv("c1234", 14'd1234, 16'h1234, 1'b0, 1'b0);
    cyc();
    chk("c1234_done_pulse", 32'(bus.done), 32'd0);
    chk("c1234_bcd_hold", 32'(bus.bcd_out), 32'h1234);

    // Back to back: start the second conversion in the done cycle of the first.
    conv("c0", 14'd0, 16'h0000, 1'b0, 1'b0);
    conv("c9999", 14'd9999, 16'h9999, 1'b0, 1'b0);
    chk("b2b_period", 32'(lat + 1), 32'd16);
    cyc();

    // Small values and the overflow cases.
    conv("c9", 14'd9, 16'h0009, 1'b0, 1'b0);
    conv("c10", 14'd10, 16'h0010, 1'b0, 1'b0);
    conv("c12345", 14'd12345, exp_big, 1'b1, 1'b0);
    conv("c16383", 14'd16383, exp_max, 1'b1, 1'b0);
    cyc();

    // While busy, start and bin_in must be ignored: only one done is expected.
    conv("c42", 14'd42, 16'h0042, 1'b0, 1'b1);
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.done) extra_done++;
    end
    chk("c42_extra_done", 32'(extra_done), 32'd0);
    chk("c42_bcd_hold", 32'(bus.bcd_out), 32'h0042);

    // Asynchronous reset during shift 6 of a 5678 conversion.
    bus.start  = 1'b1;
    bus.bin_in = 14'd5678;
    cyc();                               // E0
    bus.start = 1'b0;
    repeat (6) cyc();                    // E1..E6
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    reset_p = 1'b1;
    #1;
    chk("abort_cleared", {13'd0, bus.busy, bus.done, bus.ovf, bus.bcd_out}, 32'd0);
    cyc();
    reset_p = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (bus.done || bus.busy) extra_done++;
    end
    chk("abort_no_done", 32'(extra_done), 32'd0);
    chk("abort_bcd_idle", 32'(bus.bcd_out), 32'd0);
    conv("c5678", 14'd5678, 16'h5678, 1'b0, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Multi-cycle binary-to-BCD converter (shift-and-add-3) with a start/busy/done handshake. It sits between the button-driven binary counter and the 4-digit FND controller, and replaces divide/modulo arithmetic with a small iterative datapath. Output is four packed BCD digits plus an overflow flag for values above 9999.

## Interface
- IN_W, 14, width of the binary input; legal range 4..14.
- clk  input  1  system clock, rising-edge.
- reset_p  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- bin_in  input  IN_W  unsigned binary value; captured on the edge that accepts start.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse; bcd_out/ovf valid from this cycle on.
- bcd_out  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- ovf  output  1  result exceeded 9999.

## Operation
- Internal state: 20-bit BCD accumulator (5 digits), IN_W-bit shift register, 4-bit shift counter, FSM IDLE/SHIFT/DONE.
- IDLE: on start=1, load shift register with bin_in, clear accumulator, counter=IN_W, busy=1, go to SHIFT.
- SHIFT, each cycle: every accumulator digit >=5 gets +3; then {acc, shreg} shifts left by 1; counter decrements; at counter 1→0 go to DONE.
- DONE: register bcd_out from acc[15:0] (or the saturated value, see Configuration), ovf = (acc[19:16] != 0), done=1, busy=0, go to IDLE.
- start while busy: ignored, no queuing; bin_in changes while busy have no effect.
- bcd_out/ovf hold the last result until the next DONE; never show intermediate values.
- Digit values in bcd_out are always 0..9.

## Timing
- Reset (asynchronous, any state including mid-conversion): FSM=IDLE, busy=0, done=0, bcd_out=16'h0000, ovf=0, accumulator/counter cleared; no done is produced for the aborted conversion.
- Edge E0 accepts start → busy=1 after E0.
- Edges E1..E_IN_W perform shifts; state=DONE after E_IN_W.
- Edge E_(IN_W+1): done=1, busy=0, bcd_out/ovf updated. Latency start-edge→done = IN_W+1 cycles (15 for IN_W=14).
- Edge E_(IN_W+2): done=0; start asserted in the done cycle is accepted here. Minimum back-to-back period IN_W+2 cycles.
- start held high continuously: a new conversion every IN_W+2 cycles.

## Configuration
- BIN_TO_BCD_SAT_EN defined: when ovf, bcd_out = 16'h9999 (display saturates).
- Not defined: bcd_out = lower four digits of the true value (e.g. 12345 → 16'h2345); ovf still flags the condition.
- ovf, latency and handshake are identical in both builds.

## Test plan
- Reset released, no start → busy=0, done=0, bcd_out=16'h0000, ovf=0 for 20 cycles.
- IN_W=14, bin_in=1234, one-cycle start → done exactly 15 cycles after the accepting edge, bcd_out=16'h1234, ovf=0, busy high for exactly 15 cycles.
- bin_in=0 then 9999 back-to-back (start in done cycle) → 16'h0000 then 16'h9999, ovf=0 both, second done 16 cycles after first.
- bin_in=12345 → ovf=1; bcd_out=16'h9999 with BIN_TO_BCD_SAT_EN, 16'h2345 without.
- start pulses and bin_in=7777 applied while busy during a 42 conversion → only one done, bcd_out=16'h0042.
- reset_p pulsed at shift 6 of a 5678 conversion → outputs cleared immediately, no done; subsequent start with 5678 → 16'h5678.
